module_ram_arbiter: RTL
=======================

// Module: module_ram_arbiter
// PURPOSE
//  Shares the single-port 256x8 program/data RAM between the CPU memory port and the
//  program-loader port (host/debug side). It arbitrates requests, sequences each RAM access
//  through its one-cycle read latency, returns read data with a one-cycle ack pulse, and
//  enforces a loader lock that holds the CPU off the bus during program download.
// PARAMETERS
//  ADDR_W      8  RAM address width
//  DATA_W      8  RAM data width
//  STARVE_MAX  4  consecutive CPU grants allowed while loader waits before the loader is forced in (1..15)
// PORTS
//  clk_qzt     in   1       single system clock; all logic on posedge
//  reset_n     in   1       asynchronous, active-low reset
//  cpu_req     in   1       CPU access request; addr/we/wdata stable while high until cpu_ack
//  cpu_we      in   1       1=write, 0=read
//  cpu_addr    in   ADDR_W  CPU address
//  cpu_wdata   in   DATA_W  CPU write data
//  cpu_ack     out  1       one-cycle pulse: access complete (rdata valid same cycle for reads)
//  cpu_rdata   out  DATA_W  CPU read data, held until next CPU read ack
//  cpu_hold    out  1       1 = CPU must stall (loader lock in force)
//  ldr_req     in   1       loader request; same rules as cpu_req
//  ldr_we      in   1       loader write enable
//  ldr_addr    in   ADDR_W  loader address
//  ldr_wdata   in   DATA_W  loader write data
//  ldr_lock    in   1       loader owns RAM exclusively while high
//  ldr_ack     out  1       loader ack pulse
//  ldr_rdata   out  DATA_W  loader read data
//  ram_en      out  1       RAM access strobe, one cycle per access
//  ram_we      out  1       RAM write enable (valid with ram_en)
//  ram_addr    out  ADDR_W  RAM address
//  ram_wdata   out  DATA_W  RAM write data
//  ram_rdata   in   DATA_W  RAM read data, valid one cycle after ram_en with ram_we=0
//  owner       out  2       current bus owner: 0 none, 1 CPU, 2 loader
// BEHAVIOUR
//  - Reset (reset_n=0, async): state IDLE; ram_en/ram_we/ram_addr/ram_wdata=0; cpu_ack/ldr_ack=0;
//    cpu_rdata/ldr_rdata=0; cpu_hold=0; owner=0; starve counter=0. In-flight access is abandoned, no ack.
//  - FSM states: IDLE -> ACCESS -> RESP -> (ACCESS | IDLE).
//    IDLE:   if a request is eligible, register winner's addr/we/wdata onto ram_*, owner=winner, go ACCESS.
//    ACCESS: ram_en=1 for exactly this cycle; go RESP.
//    RESP:   ram_en=0; pulse winner's ack; on read, winner's rdata <= ram_rdata in the same edge.
//            Re-arbitrate in this cycle: if eligible request present go ACCESS with new winner, else IDLE, owner=0.
//  - Latency: req high in IDLE at edge N -> ram_en at N+1 -> ack at N+2. Sustained throughput is one access per 2 cycles.
//  - A req still high in the cycle its ack is seen is a NEW transaction, so requesters drop req after ack
//    unless issuing another.
//  - Eligibility/priority: ldr_lock=1 -> only loader eligible. Otherwise CPU has priority, except when the
//    loader is requesting and starve counter == STARVE_MAX; then the loader wins.
//  - Starve counter: +1 per CPU grant while ldr_req=1 (saturates at STARVE_MAX); cleared on any loader grant
//    or when ldr_req=0.
//  - cpu_hold: registered; 1 from the cycle after ldr_lock is sampled high, with no CPU access in ACCESS/RESP,
//    until the cycle after ldr_lock is sampled low. Lock rising mid CPU access: that access completes and is
//    acked, then hold asserts.
//  - Simultaneous cpu_req & ldr_req in IDLE, no lock, counter < STARVE_MAX: CPU wins; the loader is served at
//    the next RESP re-arbitration if the CPU has dropped req.
//  - Address arithmetic none; wrap not applicable; ram_addr is passed through unmodified.
//  - Requests changing addr/we/wdata before ack: undefined, flagged by assertion in simulation.
// STRUCTURE
//  - Package ram_arb_pkg: state enum (ST_IDLE, ST_ACCESS, ST_RESP), owner codes (OWN_NONE=0, OWN_CPU=1,
//    OWN_LDR=2), STARVE_MAX default.
//  - Sub-module module_arb_starve_cnt: saturating counter with inc/clr inputs and a sat output, reused for
//    future I/O port arbitration.
//  - Top: FSM, winner mux, ack/rdata registers, cpu_hold register.
// TESTING
//  1 Reset mid-access: reset_n low during ACCESS of CPU read @0x10 -> all outputs 0 next sample, no cpu_ack after release.
//  2 CPU read @0x05 (RAM holds 0xA7) from IDLE -> ram_en at N+1 with addr 0x05, cpu_ack at N+2, cpu_rdata=0xA7.
//  3 Loader writes 0x3E@0x80 while CPU idle -> ram_we=1, ram_wdata=0x3E, ldr_ack at N+2; CPU read @0x80 then returns 0x3E.
//  4 cpu_req and ldr_req held continuously with distinct addrs, STARVE_MAX=4 -> grant order CPU x4, LDR, CPU x4, LDR, ...
//  5 ldr_lock raised during CPU write -> CPU write acked, cpu_hold=1 next cycle, pending cpu_req not granted until
//    lock drops, then granted within 3 cycles.
//  6 Back-to-back loader reads 0x00..0x03 with req held -> ldr_ack every 2 cycles, rdata matches RAM image.

Source files
------------

// File: rtl/ram_arb_pkg.sv
// Shared types for the program/data RAM arbiter.
// State, owner codes and default sizing.
package ram_arb_pkg;

  localparam int ADDR_W_D     = 8;
  localparam int DATA_W_D     = 8;
  localparam int STARVE_MAX_D = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_LDR  = 2'd2
  } owner_e;

endpackage

// File: rtl/module_arb_starve_cnt.sv
// Saturating grant counter for requester fairness.
// clr wins over inc; sat flags the limit.
module module_arb_starve_cnt #(
  parameter int MAX = 4,
  parameter int W   = 4
) (
  input  logic clk_qzt,
  input  logic reset_n,
  input  logic inc,
  input  logic clr,
  output logic sat
);

  logic [W-1:0] cnt;

  assign sat = (cnt == W'(MAX));

  // count up to MAX, clear on demand
  always_ff @(posedge clk_qzt or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && !sat) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/module_ram_arbiter.sv
// CPU / loader arbiter for the single-port RAM.
// Two-cycle access: ACCESS strobes, RESP acks.
module module_ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_D,
  parameter int DATA_W     = DATA_W_D,
  parameter int STARVE_MAX = STARVE_MAX_D
) (
  input  logic              clk_qzt,
  input  logic              reset_n,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_hold,
  input  logic              ldr_req,
  input  logic              ldr_we,
  input  logic [ADDR_W-1:0] ldr_addr,
  input  logic [DATA_W-1:0] ldr_wdata,
  input  logic              ldr_lock,
  output logic              ldr_ack,
  output logic [DATA_W-1:0] ldr_rdata,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [1:0]        owner
);

  state_e            state_q, state_d;
  owner_e            own_q, win_own;
  logic              acc_we_q;
  logic              hold_q;
  logic [DATA_W-1:0] cpu_rd_q, ldr_rd_q;
  logic              win_we;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_wdata;
  logic              arb_slot, cpu_elig, pick_ldr;
  logic              grant_cpu, grant_ldr, grant_any;
  logic              starve_sat;
  logic              resp;

  assign arb_slot  = (state_q == ST_IDLE) || (state_q == ST_RESP);
  assign cpu_elig  = cpu_req & ~ldr_lock;
  assign pick_ldr  = ldr_req & (~cpu_elig | starve_sat);
  assign grant_ldr = arb_slot & pick_ldr;
  assign grant_cpu = arb_slot & cpu_elig & ~pick_ldr;
  assign grant_any = grant_cpu | grant_ldr;

  module_arb_starve_cnt #(
    .MAX (STARVE_MAX),
    .W   (4)
  ) u_starve (
    .clk_qzt (clk_qzt),
    .reset_n (reset_n),
    .inc     (grant_cpu & ldr_req),
    .clr     (grant_ldr | ~ldr_req),
    .sat     (starve_sat)
  );

  // winner mux
  always_comb begin
    win_own   = OWN_NONE;
    win_we    = 1'b0;
    win_addr  = '0;
    win_wdata = '0;
    unique case (1'b1)
      grant_ldr: begin
        win_own   = OWN_LDR;
        win_we    = ldr_we;
        win_addr  = ldr_addr;
        win_wdata = ldr_wdata;
      end
      grant_cpu: begin
        win_own   = OWN_CPU;
        win_we    = cpu_we;
        win_addr  = cpu_addr;
        win_wdata = cpu_wdata;
      end
      default: ;
    endcase
  end

  // next-state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (grant_any) state_d = ST_ACCESS;
      ST_ACCESS: state_d = ST_RESP;
      ST_RESP:   state_d = grant_any ? ST_ACCESS : ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // state, owner and RAM command registers
  always_ff @(posedge clk_qzt or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      own_q     <= OWN_NONE;
      acc_we_q  <= 1'b0;
      ram_en    <= 1'b0;
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
    end else begin
      state_q <= state_d;
      ram_en  <= grant_any;
      ram_we  <= grant_any & win_we;
      if (grant_any) begin
        own_q     <= win_own;
        acc_we_q  <= win_we;
        ram_addr  <= win_addr;
        ram_wdata <= win_wdata;
      end else if (state_q != ST_ACCESS) begin
        own_q <= OWN_NONE;
      end
    end
  end

  assign resp    = (state_q == ST_RESP);
  assign cpu_ack = resp & (own_q == OWN_CPU);
  assign ldr_ack = resp & (own_q == OWN_LDR);
  assign owner   = own_q;

  // read data is live during the ack, then held
  assign cpu_rdata = (cpu_ack & ~acc_we_q) ? ram_rdata : cpu_rd_q;
  assign ldr_rdata = (ldr_ack & ~acc_we_q) ? ram_rdata : ldr_rd_q;

  // capture read data as the ack completes
  always_ff @(posedge clk_qzt or negedge reset_n) begin
    if (!reset_n) begin
      cpu_rd_q <= '0;
      ldr_rd_q <= '0;
    end else begin
      if (cpu_ack && !acc_we_q) cpu_rd_q <= ram_rdata;
      if (ldr_ack && !acc_we_q) ldr_rd_q <= ram_rdata;
    end
  end

  // CPU stall: waits for an in-flight CPU access to finish
  always_ff @(posedge clk_qzt or negedge reset_n) begin
    if (!reset_n) begin
      hold_q <= 1'b0;
    end else begin
      hold_q <= ldr_lock &
        (hold_q | ~(state_q == ST_ACCESS && own_q == OWN_CPU));
    end
  end

  assign cpu_hold = hold_q;

  cpu_req_stable: assert property (
    @(posedge clk_qzt) disable iff (!reset_n)
    (state_q == ST_ACCESS && own_q == OWN_CPU) |->
    (cpu_req && cpu_we == acc_we_q &&
     cpu_addr == ram_addr && cpu_wdata == ram_wdata));

  ldr_req_stable: assert property (
    @(posedge clk_qzt) disable iff (!reset_n)
    (state_q == ST_ACCESS && own_q == OWN_LDR) |->
    (ldr_req && ldr_we == acc_we_q &&
     ldr_addr == ram_addr && ldr_wdata == ram_wdata));

endmodule
